memscrub: RTL

MEMSCRUB -- requirements
Module: memscrub

---
 rtl/memscrub_pkg.sv | 29 ++
 rtl/memscrub_parchk.sv | 13 +
 rtl/memscrub.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/memscrub_pkg.sv
// Shared definitions for the memory scrubber: ARM register map, ID word,
// FSM state encoding and the countdown reload helper.
package memscrub_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 18;
  localparam int CNT_W  = 16;

  localparam logic [2:0] REG_ID  = 3'd0;
  localparam logic [2:0] REG_CTL = 3'd1;
  localparam logic [2:0] REG_CNT = 3'd2;
  localparam logic [2:0] REG_ERR = 3'd3;

  localparam logic [31:0] ID_VALUE = 32'h5343_0001;
  localparam logic [31:0] BAD_REG  = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_RD   = 3'd2,
    ST_CHK  = 3'd3
  } scrub_state_e;

  // WAIT dwells for 2^ratesel cycles: reload with 2^ratesel-1, leave at zero.
  function automatic logic [CNT_W-1:0] wait_load(input logic [3:0] ratesel);
    return (CNT_W'(1) << ratesel) - CNT_W'(1);
  endfunction

endpackage

// File: rtl/memscrub_parchk.sv
// Odd-parity checker for one 18-bit bigmem word (two 9-bit bytes).
// err[1] flags the upper byte, err[0] the lower byte.
module memscrub_parchk
  import memscrub_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [1:0]        err
);

  assign err[1] = ~^data[DATA_W-1:DATA_W/2];
  assign err[0] = ~^data[DATA_W/2-1:0];

endmodule

// File: rtl/memscrub.sv
// Background parity scrubber for the bigmem block RAM, sharing the RAM port
// with bigmem (bigmem always has priority). Define MEMSCRUB_ERRLOG_EN to keep
// the first failing address in register 3.
//
// state | meaning
// IDLE  | scrubbing disabled
// WAIT  | rate countdown between words
// RD    | RAM read of the scrub address issued
// CHK   | read data returned, parity checked, address advanced
module memscrub
  import memscrub_pkg::*;
(
  input  logic              CLOCK,
  input  logic              reset_l,
  input  logic              armwrite,
  input  logic [2:0]        armraddr,
  input  logic [2:0]        armwaddr,
  input  logic [31:0]       armwdata,
  output logic [31:0]       armrdata,
  input  logic [ADDR_W-1:0] bm_addr,
  input  logic [DATA_W-1:0] bm_dout,
  input  logic              bm_enab,
  input  logic [1:0]        bm_wena,
  output logic [DATA_W-1:0] bm_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_enab,
  output logic [1:0]        ram_wena,
  input  logic [DATA_W-1:0] ram_din
);

  scrub_state_e state, state_nxt;

  logic              enable;
  logic [3:0]        ratesel;
  logic [ADDR_W-1:0] limit;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       errcount, passcount;
  logic [15:0]       err_base, pass_base;
  logic              errvalid;
  logic [ADDR_W-1:0] err_addr;

  logic       wr_ctl, wr_cnt;
  logic       load_cnt, dec_cnt, do_check;
  logic [1:0] par_err;
  logic       word_err, at_limit;
  logic       unused_wdata;

  assign wr_ctl = armwrite && (armwaddr == REG_CTL);
  assign wr_cnt = armwrite && (armwaddr == REG_CNT);
  assign unused_wdata = ^{armwdata[30:28], armwdata[23:17]};

  memscrub_parchk u_parchk (
    .data (ram_din),
    .err  (par_err)
  );

  always_ff @(posedge CLOCK or negedge reset_l) begin
    if (!reset_l) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_cnt  = 1'b0;
    dec_cnt   = 1'b0;
    do_check  = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_WAIT;
          load_cnt  = 1'b1;
        end
        ST_WAIT: begin
          if (cnt == '0) state_nxt = ST_RD;
          else           dec_cnt   = 1'b1;
        end
        ST_RD: begin
          // bigmem stole the port, so the read never happened
          if (bm_enab) begin
            state_nxt = ST_WAIT;
            load_cnt  = 1'b1;
          end else begin
            state_nxt = ST_CHK;
          end
        end
        ST_CHK: begin
          state_nxt = ST_WAIT;
          load_cnt  = 1'b1;
          do_check  = !bm_enab;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign word_err = do_check && (par_err != 2'b00);
  assign at_limit = (addr == limit);

  always_ff @(posedge CLOCK or negedge reset_l) begin
    if (!reset_l) begin
      enable  <= 1'b0;
      ratesel <= '0;
      limit   <= '0;
    end else if (wr_ctl) begin
      enable  <= armwdata[31];
      ratesel <= armwdata[27:24];
      limit   <= armwdata[16:0];
    end
  end

  always_ff @(posedge CLOCK or negedge reset_l) begin
    if (!reset_l)      cnt <= '0;
    else if (load_cnt) cnt <= wait_load(ratesel);
    else if (dec_cnt)  cnt <= cnt - CNT_W'(1);
  end

  always_ff @(posedge CLOCK or negedge reset_l) begin
    if (!reset_l)      addr <= '0;
    else if (wr_ctl)   addr <= '0;
    else if (do_check) addr <= at_limit ? '0 : addr + ADDR_W'(1);
  end

  // A clear and a count landing together leave the new count in place.
  assign err_base  = wr_cnt ? '0 : errcount;
  assign pass_base = wr_cnt ? '0 : passcount;

  always_ff @(posedge CLOCK or negedge reset_l) begin
    if (!reset_l) begin
      errcount  <= '0;
      passcount <= '0;
    end else begin
      errcount  <= (word_err && (err_base != 16'hFFFF)) ? err_base + 16'd1 : err_base;
      passcount <= (do_check && at_limit) ? pass_base + 16'd1 : pass_base;
    end
  end

`ifdef MEMSCRUB_ERRLOG_EN
  logic wr_err;
  assign wr_err = armwrite && (armwaddr == REG_ERR);

  always_ff @(posedge CLOCK or negedge reset_l) begin
    if (!reset_l) begin
      errvalid <= 1'b0;
      err_addr <= '0;
    end else if (word_err && (!errvalid || wr_err)) begin
      errvalid <= 1'b1;
      err_addr <= addr;
    end else if (wr_err) begin
      errvalid <= 1'b0;
    end
  end
`else
  assign errvalid = 1'b0;
  assign err_addr = '0;
`endif

  assign bm_din   = ram_din;
  assign ram_addr = bm_enab ? bm_addr : addr;
  assign ram_dout = bm_enab ? bm_dout : '0;
  assign ram_wena = bm_enab ? bm_wena : 2'b00;
  assign ram_enab = bm_enab ? 1'b1 : (state == ST_RD);

  always_comb begin
    armrdata = BAD_REG;
    case (armraddr)
      REG_ID:  armrdata = ID_VALUE;
      REG_CTL: armrdata = {enable, 3'b000, ratesel, 7'b0, limit};
      REG_CNT: armrdata = {errcount, passcount};
      REG_ERR: armrdata = {errvalid, state, 11'b0, err_addr};
      default: armrdata = BAD_REG;
    endcase
  end

endmodule
